// File: rtl/jtkiwi_objram_if.sv
// CPU bus into the object attribute memory.
//   cpu_addr  byte address within the selected region
//   cpu_dout  write data from the CPU
//   cpu_rnw   1 = read, 0 = write
//   lut_cs    LUT region select
//   y_cs      Y-table region select
//   ctrl_cs   control-register select
//   cpu_din   registered read data back to the CPU
interface jtkiwi_objram_if;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rnw;
  logic        lut_cs;
  logic        y_cs;
  logic        ctrl_cs;
  logic [7:0]  cpu_din;

  modport master (
    output cpu_addr, cpu_dout, cpu_rnw, lut_cs, y_cs, ctrl_cs,
    input  cpu_din
  );

  modport slave (
    input  cpu_addr, cpu_dout, cpu_rnw, lut_cs, y_cs, ctrl_cs,
    output cpu_din
  );
endinterface

// File: rtl/jtkiwi_objram.sv
// Object attribute memory for the SETA object processor (CPU write side).
// The CPU writes a 16-bit code/attribute LUT and a Y table; the scanner reads
// the LUT directly and the Y table from a shadow copy that is refreshed at the
// start of every vblank, so mid-frame CPU edits never tear sprites.
// Ports:
//   rst, clk            asynchronous active-high reset, clock
//   bus                 CPU bus (slave side)
//   LVBL                active-low vertical blank
//   lut_addr/lut_data   scanner LUT read, 1 clk latency
//   y_addr/y_data       scanner Y read from the shadow, 1 clk latency
//   page, flip          control bits latched at the frame boundary
//   busy                copy engine active
module jtkiwi_objram #(
  parameter int LUT_AW = 12,
  parameter int Y_AW   = 9
) (
  input  logic              rst,
  input  logic              clk,
  jtkiwi_objram_if.slave    bus,
  input  logic              LVBL,
  input  logic [LUT_AW-1:0] lut_addr,
  output logic [15:0]       lut_data,
  input  logic [Y_AW-1:0]   y_addr,
  output logic [7:0]        y_data,
  output logic              page,
  output logic              flip,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, COPY, LAST} state_t;

  state_t state, state_nx;

  logic [7:0] lut_lo [0:(1<<LUT_AW)-1];
  logic [7:0] lut_hi [0:(1<<LUT_AW)-1];
  logic [7:0] cpu_y  [0:(1<<Y_AW)-1];
  logic [7:0] shadow [0:(1<<Y_AW)-1];

  logic [7:0]        ctrl0, ctrl1;
  logic [7:0]        cpy_data;
  logic [Y_AW-1:0]   cnt, sh_addr;
  logic [LUT_AW-1:0] lut_idx;
  logic [Y_AW-1:0]   y_idx;
  logic              lvbl_l, frame_start;
  logic              lut_we, y_we, ctrl_we, rd, sh_we;

  assign lut_idx     = bus.cpu_addr[LUT_AW-1:0];
  assign y_idx       = bus.cpu_addr[Y_AW-1:0];
  assign lut_we      = bus.lut_cs  & ~bus.cpu_rnw;
  assign y_we        = bus.y_cs    & ~bus.cpu_rnw;
  assign ctrl_we     = bus.ctrl_cs & ~bus.cpu_rnw;
  assign rd          = bus.cpu_rnw & (bus.lut_cs | bus.y_cs | bus.ctrl_cs);
  // Edges seen while a copy is running are ignored entirely (no relatch).
  assign frame_start = lvbl_l & ~LVBL & (state == IDLE);
  assign busy        = (state != IDLE);

  // The shadow write trails the CPU-Y read by one cycle. In LAST the counter
  // has wrapped to 0, so cnt-1 addresses the final entry.
  assign sh_we   = ((state == COPY) && (cnt != '0)) || (state == LAST);
  assign sh_addr = cnt - 1'b1;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (frame_start && !ctrl1[5]) state_nx = COPY;
      COPY:    if (cnt == '1) state_nx = LAST;
      LAST:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (lut_we && !bus.cpu_addr[12]) lut_lo[lut_idx] <= bus.cpu_dout;
    if (lut_we &&  bus.cpu_addr[12]) lut_hi[lut_idx] <= bus.cpu_dout;
    if (y_we)  cpu_y[y_idx]    <= bus.cpu_dout;
    if (sh_we) shadow[sh_addr] <= cpy_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cpy_data    <= '0;
      lvbl_l      <= 1'b0;
      ctrl0       <= '0;
      ctrl1       <= '0;
      page        <= 1'b0;
      flip        <= 1'b0;
      bus.cpu_din <= '0;
      lut_data    <= '0;
      y_data      <= '0;
    end else begin
      state  <= state_nx;
      lvbl_l <= LVBL;

      if (state == IDLE)      cnt <= '0;
      else if (state == COPY) cnt <= cnt + 1'b1;

      // A CPU write to the entry being fetched this cycle must still make it
      // into this frame's shadow.
      cpy_data <= (y_we && (y_idx == cnt)) ? bus.cpu_dout : cpu_y[cnt];

      if (ctrl_we && !bus.cpu_addr[0]) ctrl0 <= bus.cpu_dout;
      if (ctrl_we &&  bus.cpu_addr[0]) ctrl1 <= bus.cpu_dout;

      // Non-blocking reads of ctrl0/ctrl1 give the pre-write values.
      if (frame_start) begin
        flip <= ctrl0[6];
        page <= ctrl1[6];
      end

      if (rd) begin
        if (bus.lut_cs)
          bus.cpu_din <= bus.cpu_addr[12] ? lut_hi[lut_idx] : lut_lo[lut_idx];
        else if (bus.y_cs)
          bus.cpu_din <= cpu_y[y_idx];
        else
          bus.cpu_din <= bus.cpu_addr[0] ? ctrl1 : ctrl0;
      end

      lut_data <= {lut_hi[lut_addr], lut_lo[lut_addr]};
      y_data   <= shadow[y_addr];
    end
  end

endmodule

// File: doc/jtkiwi_objram.md
Name: jtkiwi_objram

Overview:
- CPU-facing object attribute memory for the SETA object processor. It is the write side of the object-scanner interface: the CPU writes the 16-bit code/attribute LUT and the Y table, and the scanner reads them through the lut_addr/lut_data and y_addr/y_data ports.
- A copy engine snapshots the CPU Y table into a display-side shadow at the start of each vblank. This keeps mid-frame CPU edits from tearing sprites.
- Display control bits (page, flip) are latched at the same frame boundary.

Parameters:
- LUT_AW, 12, LUT word-address width (4096 x 16).
- Y_AW, 9, Y-table address width (512 x 8).

Ports:
- rst  in  1  reset, asynchronous, active-high.
- clk  in  1  clock.
- cpu_addr  in  13  CPU byte address within the selected region.
- cpu_dout  in  8  CPU write data.
- cpu_rnw  in  1  1 = read, 0 = write.
- lut_cs  in  1  LUT region select.
- y_cs  in  1  Y-table region select.
- ctrl_cs  in  1  control-register select.
- cpu_din  out  8  CPU read data.
- LVBL  in  1  active-low vertical blank.
- lut_addr  in  12  scanner LUT word address.
- lut_data  out  16  scanner LUT data.
- y_addr  in  9  scanner Y address.
- y_data  out  8  scanner Y data, from the shadow.
- page  out  1  frame-latched LUT page.
- flip  out  1  frame-latched screen flip.
- busy  out  1  copy engine active.

Behaviour:
- Reset values:
  - cpu_din, lut_data, y_data, page, flip, busy = 0.
  - ctrl0 and ctrl1 = 0; copy state = IDLE; counter = 0.
  - RAM contents are not cleared.
- LUT mapping:
  - cpu_addr[12] = 0 selects the low byte, 1 selects the high byte.
  - cpu_addr[11:0] is the word index.
  - A write updates only the selected byte lane.
- Y table: the CPU addresses cpu_addr[8:0] of the CPU-side Y RAM. cpu_addr[12:9] are ignored.
- Control registers:
  - Selected by cpu_addr[0].
  - ctrl0[6] = flip.
  - ctrl1[6] = page.
  - ctrl1[5] = freeze: a 1 suppresses the vblank copy.
  - Other bits are stored and read back unchanged.
- Writes: take effect on the clk edge where cs=1 and cpu_rnw=0.
- CPU reads:
  - cpu_din is registered and valid 1 clk after cs with cpu_rnw=1. It is muxed by whichever cs is active.
  - With no cs active, cpu_din holds its value.
  - A Y read returns the CPU-side RAM, not the shadow.
- Scanner reads:
  - lut_data = LUT[lut_addr] and y_data = shadow[y_addr], both registered with 1 clk latency on every clk, independent of cen.
  - A CPU write to the same LUT word in the same cycle returns the old data (read-first). The new data is visible on the next read.
- Frame boundary: detected as the LVBL falling edge (registered previous LVBL = 1, current = 0). On that edge:
  - flip <= ctrl0[6] and page <= ctrl1[6]. The value sampled is the register value before any same-cycle CPU write.
  - If ctrl1[5] = 0, the engine enters COPY.
- Copy state machine (IDLE, COPY, LAST):
  - IDLE: busy = 0.
  - COPY:
    - busy = 1.
    - Each clk, read CPU-Y[cnt] on the second port, and write the previous cycle's data to shadow[cnt-1].
    - cnt increments each clk.
    - When cnt = 511 the engine goes to LAST.
  - LAST: writes shadow[511], then returns to IDLE.
  - Total busy time is exactly 513 clk.
- Copy boundary conditions:
  - A CPU Y write during COPY always lands in CPU-Y. It reaches the shadow in this frame only if its address is still >= cnt.
  - An LVBL falling edge during COPY is ignored: no restart and no relatch.
  - Setting freeze mid-copy does not abort the copy in progress.
  - Reset mid-copy aborts immediately. Shadow bytes already written keep their values.
- Scanner timing: the scanner is idle during vblank lines, so y_data during COPY is unspecified. It must simply not glitch outside of COPY.

Test Plan:
- Reset: pulse rst during COPY at cnt = 100 -> busy = 0 and page = flip = 0 on the next clk. Shadow[0..98] holds the copied values; shadow[100..511] is unchanged.
- LUT byte lanes: write 0x34 at address 0x0005 and 0x12 at address 0x1005 -> lut_addr = 5 gives lut_data = 0x1234 one clk later. cpu_din reads 0x34 and 0x12 back.
- Copy: fill CPU-Y[i] = i[7:0], then drop LVBL -> busy high for exactly 513 clk. Afterwards y_data = 0x7F for y_addr = 0x17F and 0xFF for y_addr = 0x1FF.
- Tear protection: write CPU-Y[10] = 0xAA mid-frame (LVBL = 1) -> y_data at address 10 keeps its old value until the next vblank copy completes, then reads 0xAA.
- Freeze and latch:
  - Set ctrl1 = 0x60 and ctrl0 = 0x40, then drop LVBL -> page = 1, flip = 1, busy stays 0, shadow unchanged.
  - A ctrl0 write of 0x00 on the same edge cycle leaves flip = 1 until the next frame.
- Mid-copy edit: while COPY is at cnt = 200, write CPU-Y[300] = 0x55 and CPU-Y[50] = 0x66 -> after the copy, shadow[300] = 0x55 and shadow[50] keeps the pre-copy CPU value.
